wbck_arbiter: RTL

Writeback arbiter and register scoreboard for the integer register file. It shares the register file's single write port among `NREQ` writeback sources using round-robin arbitration with a valid/ready handshake. It also keeps a pending bit per architectural register for long-latency operations, and raises a hazard to the dispatch stage when a source or destination operand is still pending. It sits between the execution units (ALU, LSU, mul/div) and the register file write port (`wbck_dest_wen/idx/dat`).

---
 rtl/wbck_arbiter_pkg.sv | 12 +
 rtl/wbck_arbiter_if.sv | 28 ++
 rtl/wbck_arbiter_rr_arb.sv | 51 +++++
 rtl/wbck_arbiter.sv | 80 ++++++++
 4 files changed

// File: rtl/wbck_arbiter_pkg.sv
// Shared constants for the integer writeback path: data/index widths and
// the fixed requester slot assignment used by dispatch and the execution units.
package wbck_arbiter_pkg;

  localparam int unsigned WB_XLEN  = 32;
  localparam int unsigned WB_RFIDX = 5;

  localparam int unsigned WB_ALU = 0;
  localparam int unsigned WB_LSU = 1;
  localparam int unsigned WB_MDV = 2;

endpackage

// File: rtl/wbck_arbiter_if.sv
// Writeback request bus from the execution units plus the register file write port.
interface wbck_arbiter_if
  import wbck_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned XLEN  = WB_XLEN,
  parameter int unsigned RFIDX = WB_RFIDX
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*RFIDX-1:0] req_idx;
  logic [NREQ*XLEN-1:0]  req_dat;
  logic [NREQ-1:0]       req_ready;
  logic                  wbck_dest_wen;
  logic [31:0]           wbck_dest_idx;
  logic [XLEN-1:0]       wbck_dest_dat;

  modport master (
    output req_valid, req_idx, req_dat,
    input  req_ready, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat
  );

  modport slave (
    input  req_valid, req_idx, req_dat,
    output req_ready, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat
  );

endinterface

// File: rtl/wbck_arbiter_rr_arb.sv
// Parameterised round-robin arbiter; the pointer moves past the winner after
// every grant. Grants are forced low while reset is asserted.
module rr_arb #(
  parameter  int unsigned NREQ = 3,
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx,
  output logic            gnt_any
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win;
  logic          any;

  always_comb begin
    win = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned   c;
      logic [PW-1:0] ci;
      c = 32'(ptr_q) + i;
      if (c >= NREQ) c = c - NREQ;
      ci = PW'(c);
      if (!any && req[ci]) begin
        any = 1'b1;
        win = ci;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (any && rst_n) gnt[win] = 1'b1;
  end

  assign gnt_idx = win;
  assign gnt_any = any & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (any) begin
      ptr_q <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/wbck_arbiter.sv
// Shares the register file write port among NREQ writeback sources and keeps
// a pending bit per register for long-latency producers.
module wbck_arbiter
  import wbck_arbiter_pkg::*;
#(
  parameter int unsigned XLEN  = WB_XLEN,
  parameter int unsigned NREQ  = 3,
  parameter int unsigned RFIDX = WB_RFIDX
) (
  input  logic             clk,
  input  logic             rst_n,
  wbck_arbiter_if.slave    bus,
  input  logic             disp_valid,
  input  logic             disp_long,
  input  logic [RFIDX-1:0] disp_rd,
  input  logic [RFIDX-1:0] disp_rs1,
  input  logic [RFIDX-1:0] disp_rs2,
  output logic             disp_hazard,
  output logic [31:0]      sb_pending
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  gnt;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [RFIDX-1:0] w_idx;
  logic [XLEN-1:0]  w_dat;
  logic             xfer;
  logic             sb_set;
  logic             sb_clr;
  logic [31:0]      sb_q;
  logic [31:0]      sb_d;

  rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    w_idx = '0;
    w_dat = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        w_idx = bus.req_idx[k*RFIDX +: RFIDX];
        w_dat = bus.req_dat[k*XLEN +: XLEN];
      end
    end
  end

  assign xfer              = |(bus.req_valid & gnt);
  assign bus.req_ready     = gnt;
  assign bus.wbck_dest_wen = xfer & (w_idx != '0);
  assign bus.wbck_dest_idx = 32'(w_idx);
  assign bus.wbck_dest_dat = w_dat;

  assign disp_hazard = disp_valid & (sb_q[disp_rs1] | sb_q[disp_rs2] | sb_q[disp_rd]);
  assign sb_set      = disp_valid & disp_long & ~disp_hazard & (disp_rd != '0);
  assign sb_clr      = xfer & gnt_any & (gnt_idx != PW'(WB_ALU));

  // Set is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    sb_d = sb_q;
    if (sb_clr) sb_d[w_idx]   = 1'b0;
    if (sb_set) sb_d[disp_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  assign sb_pending = sb_q;

endmodule
